// File: rtl/myo_pwm_pkg.sv
// Shared types and helpers for the motor PWM bridge driver.
package myo_pwm_pkg;

   localparam int unsigned DUTY_W = 17;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DEAD = 2'd1,
      FWD  = 2'd2,
      REV  = 2'd3
   } state_t;

   localparam logic DIR_FWD = 1'b0;
   localparam logic DIR_REV = 1'b1;

   // |value| widened to 17 bits (so -32768 maps to 32768), clipped to period.
   function automatic logic [DUTY_W-1:0] abs_sat(input logic signed [15:0] value,
                                                 input logic [DUTY_W-1:0]  period);
      logic [DUTY_W-1:0] mag;
      mag = value[15] ? (~{value[15], value} + DUTY_W'(1)) : {1'b0, value};
      return (mag > period) ? period : mag;
   endfunction

endpackage

// File: rtl/pwm_bridge_driver.sv
// Sign-magnitude PWM H-bridge driver with dead-time on every entry into a
// driving direction and a per-period tick for aligning controller updates.
module pwm_bridge_driver
   import myo_pwm_pkg::*;
#(
   parameter int unsigned PERIOD   = 2000,
   parameter int unsigned DEADTIME = 20
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               enable,
   input  logic signed [15:0] pwmRef,
   output logic               hi_a,
   output logic               lo_a,
   output logic               hi_b,
   output logic               lo_b,
   output logic               period_tick,
   output logic [16:0]        duty,
   output logic [1:0]         state
);

   localparam int unsigned CNT_W  = $clog2(PERIOD);
   localparam int unsigned DEAD_W = $clog2(DEADTIME + 1);

   logic [CNT_W-1:0]  cnt_q, cnt_n;
   logic [DUTY_W-1:0] duty_q, duty_n;
   logic              dir_q, dir_n;
   state_t            state_q, state_n;
   logic [DEAD_W-1:0] dead_q, dead_n;
   logic              hi_a_n, lo_a_n, hi_b_n, lo_b_n, tick_n;

   logic              latch;
   logic [DUTY_W-1:0] ref_mag;
   logic              ref_dir;
   logic              high_on;

   // Next-state, latch and gate decode; gates are decoded from next-cycle values
   // so the registered outputs line up with the counter they qualify.
   always_comb begin
      latch   = (cnt_q == CNT_W'(PERIOD - 1));
      ref_mag = abs_sat(pwmRef, DUTY_W'(PERIOD));
      ref_dir = (pwmRef == '0) ? dir_q : pwmRef[15];

      cnt_n   = latch ? '0 : cnt_q + CNT_W'(1);
      duty_n  = duty_q;
      dir_n   = dir_q;
      state_n = state_q;
      dead_n  = dead_q;
      hi_a_n  = 1'b0;
      lo_a_n  = 1'b0;
      hi_b_n  = 1'b0;
      lo_b_n  = 1'b0;
      tick_n  = latch;

      if (latch) begin
         duty_n = ref_mag;
         dir_n  = ref_dir;
      end

      case (state_q)
         IDLE: begin
            if (latch && ref_mag != '0) begin
               state_n = DEAD;
               dead_n  = DEAD_W'(DEADTIME - 1);
            end
         end
         DEAD: begin
            // dir_q already holds the direction latched on entry.
            if (dead_q == '0) state_n = (dir_q == DIR_REV) ? REV : FWD;
            else              dead_n  = dead_q - DEAD_W'(1);
         end
         FWD, REV: begin
            if (latch && ref_mag != '0 && ref_dir != dir_q) begin
               state_n = DEAD;
               dead_n  = DEAD_W'(DEADTIME - 1);
            end
         end
         default: state_n = IDLE;
      endcase

      if (!enable) state_n = IDLE;

      high_on = (DUTY_W'(cnt_n) < duty_n);
      case (state_n)
         FWD: begin
            hi_a_n = high_on;
            lo_b_n = 1'b1;
         end
         REV: begin
            hi_b_n = high_on;
            lo_a_n = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         cnt_q       <= '0;
         duty_q      <= '0;
         dir_q       <= DIR_FWD;
         state_q     <= IDLE;
         dead_q      <= '0;
         hi_a        <= 1'b0;
         lo_a        <= 1'b0;
         hi_b        <= 1'b0;
         lo_b        <= 1'b0;
         period_tick <= 1'b0;
      end else begin
         cnt_q       <= cnt_n;
         duty_q      <= duty_n;
         dir_q       <= dir_n;
         state_q     <= state_n;
         dead_q      <= dead_n;
         hi_a        <= hi_a_n;
         lo_a        <= lo_a_n;
         hi_b        <= hi_b_n;
         lo_b        <= lo_b_n;
         period_tick <= tick_n;
      end
   end

   assign duty  = duty_q;
   assign state = state_q;

   // Shoot-through guards on the registered gate outputs.
   a_leg_a: assert property (@(posedge clock) !(hi_a && lo_a));
   a_leg_b: assert property (@(posedge clock) !(hi_b && lo_b));
   a_highs: assert property (@(posedge clock) !(hi_a && hi_b));

endmodule

// File: doc/pwm_bridge_driver.md
Name: pwm_bridge_driver

Overview:
- Downstream stage of the motor PID controller. Consumes the signed 16-bit pwmRef and drives one H-bridge with four gate signals, using sign-magnitude PWM.
- Inserts dead-time on every entry into a driving direction, so a high-side and low-side switch of the same leg are never on together.
- Emits a period tick that the top level may route to the controller's update_controller input, which aligns control updates to PWM periods.

Parameters:
- PERIOD, 2000: PWM period in clock cycles. Must satisfy PERIOD >= 2.
- DEADTIME, 20: all-off cycles inserted before driving. Must satisfy 1 <= DEADTIME < PERIOD.
- CNT_W, $clog2(PERIOD): width of the period counter (derived).

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- enable  in  1  bridge enable. Low forces all gates off.
- pwmRef  in  16  signed duty request. Positive = forward, negative = reverse, 0 = off.
- hi_a  out  1  leg A high-side gate.
- lo_a  out  1  leg A low-side gate.
- hi_b  out  1  leg B high-side gate.
- lo_b  out  1  leg B low-side gate.
- period_tick  out  1  one-cycle pulse at the start of each period.
- duty  out  17  latched, saturated duty magnitude (status).
- state  out  2  FSM state (status).

Behaviour:
- Reset (reset==0 at a clock edge):
  - cnt=0, state=IDLE, duty=0, dir=FWD.
  - All gates 0, period_tick=0.
- Period counter:
  - cnt counts 0..PERIOD-1 and wraps to 0. It runs regardless of enable.
  - period_tick is registered; it is 1 in exactly the cycles where cnt==0. The first tick comes PERIOD cycles after reset release.
- Latch point, the edge where cnt==PERIOD-1:
  - Sample pwmRef.
  - mag = |pwmRef| in 17 bits, so -32768 gives 32768.
  - duty = min(mag, PERIOD).
  - req_dir = sign(pwmRef). Zero keeps the previous direction.
  - New values take effect from cnt==0.
- FSM states: IDLE, DEAD, FWD, REV.
  - IDLE: all gates 0. At a latch with enable=1 and mag!=0, go to DEAD, load dead_cnt=DEADTIME, target=req_dir.
  - DEAD: all gates 0. dead_cnt decrements each cycle. At 0, go to the target state (FWD or REV). DEADTIME<PERIOD guarantees no latch falls inside DEAD.
  - FWD: hi_a = (cnt < duty); lo_b = 1; lo_a = hi_b = 0.
  - REV: hi_b = (cnt < duty); lo_a = 1; hi_a = lo_b = 0.
  - FWD/REV at a latch with mag!=0 and req_dir opposite to the current direction: go to DEAD with target = req_dir.
  - FWD/REV at a latch with mag==0: stay in state with duty=0, so the high side is off and the low side stays on.
  - enable==0 in any state: next edge gives state=IDLE and all gates 0; duty is unchanged. Re-enable takes effect only at the next latch and always passes through DEAD.
- Duty boundaries:
  - duty==0: high side never on.
  - duty>=PERIOD: high side on for the whole period.
- All gate outputs are registered; no combinational path from pwmRef or enable to any gate.
- Invariant, checked by assertion: never (hi_a & lo_a), never (hi_b & lo_b), never (hi_a & hi_b).
- Reset mid-operation: gates go to 0 on the same edge, and cnt restarts at 0.

Decomposition:
- Shared package (myo_pwm_pkg):
  - state enum {IDLE, DEAD, FWD, REV} and direction constants FWD=0, REV=1.
  - function abs_sat(ref, period) returning a 17-bit magnitude.
- No sub-module: counter, latch and FSM belong together in one always block for clarity. Target size is about 150-200 lines.

Test Plan (bench parameters PERIOD=100, DEADTIME=5):
- Reset, enable=1, pwmRef=30:
  - period_tick every 100 cycles.
  - After the first latch: 5 all-off cycles, then FWD.
  - hi_a high for cnt 5..29 in the first period, then 30 of every 100 cycles; lo_b=1 throughout.
- pwmRef switches 30 -> -50 mid-period:
  - Forward pattern continues until the latch.
  - Then 5 cycles with all gates 0.
  - Then REV: lo_a=1, hi_b high for cnt 5..49 in the first period, then 50/100.
- pwmRef=-32768:
  - duty=100, hi_b constantly 1 in REV.
  - pwmRef=0 next period: duty=0, hi_b=0, lo_a=1, no dead-time.
- enable dropped at cnt=40 in FWD:
  - All gates 0 on the next edge.
  - Re-enable at cnt=60: stays off until the latch, then 5 DEAD cycles, then FWD.
- Reset (reset=0) asserted at cnt=10 while hi_a=1:
  - All gates 0 on that edge, cnt=0.
  - After release, no drive before the first latch.
- Random pwmRef/enable, 1e5 cycles: shoot-through assertions never fire, and every FWD/REV entry is preceded by >=5 all-off cycles.
